// File: rtl/flappy_pkg.sv
// Shared types for the pipe scroller: frame geometry, game states, LFSR seed.
// Ports: none (package). Provides frame_t, game_state_t, LFSR_SEED, lfsr_next().
package flappy_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef logic [15:0][15:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CRASH
  } game_state_t;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Game bus between the scroller and its neighbours (bird physics, LED stage).
// Signals: run, bird_index in; light, step_pulse, crash, score out of the scroller.
interface pipe_scroller_if;

  logic                run;
  logic [3:0]          bird_index;
  flappy_pkg::frame_t  light;
  logic                step_pulse;
  logic                crash;
  logic [7:0]          score;

  modport master (
    output run,
    output bird_index,
    input  light,
    input  step_pulse,
    input  crash,
    input  score
  );

  modport slave (
    input  run,
    input  bird_index,
    output light,
    output step_pulse,
    output crash,
    output score
  );

endinterface

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick pipe gap positions.
// Ports: clock, RST (sync, active high, loads seed), value (current state).
module pipe_lfsr
  import flappy_pkg::*;
(
  input  logic       clock,
  input  logic       RST,
  output logic [7:0] value
);

  always_ff @(posedge clock) begin
    if (RST) value <= LFSR_SEED;
    else     value <= lfsr_next(value);
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls one-column pipes from bit 0 to bit 15, scores passes, flags crashes.
// Ports: clock, RST (sync active high), bus (slave: run, bird_index -> light,
// step_pulse, crash, score). Optional PIPE_SPEEDUP_EN shortens the step
// period by one cycle per 8 points, floored at 2 cycles.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int STEP_CYCLES = 8,
  parameter int SPACING     = 6,
  parameter int GAP         = 4
) (
  input  logic            clock,
  input  logic            RST,
  pipe_scroller_if.slave  bus
);

  localparam int DW = $clog2(STEP_CYCLES + 1);
  localparam int CW = $clog2(SPACING + 1);

  game_state_t   state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] period;
  logic [CW-1:0] col_cnt;
  logic [7:0]    lfsr;
  frame_t        light_q;
  logic [7:0]    score_q;
  logic          crash_q;
  logic          pulse_q;

  logic          collide;
  logic          wrap;
  logic          step;
  logic [3:0]    gap_top;
  logic [15:0]   nb;
  logic [15:0]   edge_col;
  logic          unused_lfsr_hi;

  pipe_lfsr u_lfsr (
    .clock (clock),
    .RST   (RST),
    .value (lfsr)
  );

  assign unused_lfsr_hi = &{1'b0, lfsr[7:4]};

  // Collision is checked on the registered frame, also while paused.
  assign collide = (state == RUN) && light_q[bus.bird_index][15];
  assign wrap    = (state == RUN) && bus.run &&
                   (div_cnt == period - DW'(1));
  // A step that lands on the collision cycle is dropped entirely.
  assign step    = wrap && !collide;

`ifdef PIPE_SPEEDUP_EN
  function automatic logic [DW-1:0] speed_period(input logic [7:0] s);
    int p;
    p = STEP_CYCLES - int'(s >> 3);
    if (p < 2) p = 2;
    return DW'(p);
  endfunction

  // Period only changes on a divider wrap so a running step is never cut.
  always_ff @(posedge clock) begin
    if (RST)       period <= DW'(STEP_CYCLES);
    else if (wrap) period <= speed_period(score_q);
  end
`else
  assign period = DW'(STEP_CYCLES);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.run) state_nxt = RUN;
      RUN:     if (collide) state_nxt = CRASH;
      CRASH:   state_nxt = CRASH;
      default: state_nxt = IDLE;
    endcase
  end

  // New column: gap rows cleared, top clamped so the gap fits the frame.
  always_comb begin
    gap_top = lfsr[3:0];
    if (gap_top > 4'(16 - GAP)) gap_top = gap_top - 4'(GAP);
    nb = '0;
    if (col_cnt == '0) begin
      for (int r = 0; r < ROWS; r++) begin
        nb[r] = (r < int'(gap_top)) ||
                (r > int'(gap_top) + GAP - 1);
      end
    end
  end

  always_comb begin
    edge_col = '0;
    for (int r = 0; r < ROWS; r++) edge_col[r] = light_q[r][15];
  end

  always_ff @(posedge clock) begin
    if (RST) begin
      state   <= IDLE;
      div_cnt <= '0;
      col_cnt <= '0;
      light_q <= '0;
      score_q <= '0;
      crash_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pulse_q <= step;
      if (collide) crash_q <= 1'b1;
      if ((state == RUN) && bus.run) begin
        div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      end
      if (step) begin
        for (int r = 0; r < ROWS; r++) begin
          light_q[r] <= {light_q[r][14:0], nb[r]};
        end
        col_cnt <= (col_cnt == CW'(SPACING - 1)) ? '0
                 : col_cnt + CW'(1);
        if ((|edge_col) && (score_q != 8'hFF)) begin
          score_q <= score_q + 8'd1;
        end
      end
    end
  end

  assign bus.light      = light_q;
  assign bus.score      = score_q;
  assign bus.crash      = crash_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a column-oriented reference model.
// Default parameters: STEP_CYCLES=8, SPACING=6, GAP=4.
module tb_pipe_scroller;
  import flappy_pkg::*;

  logic clock = 1'b0;
  logic RST;
  always #5 clock = ~clock;

  pipe_scroller_if bus ();

  pipe_scroller dut (
    .clock (clock),
    .RST   (RST),
    .bus   (bus)
  );

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  bit auto_bird = 0;

  int          m_state;
  int          m_div;
  int          m_col;
  int          m_per;
  logic [7:0]  m_lfsr;
  logic [7:0]  m_score;
  logic        m_crash;
  logic [15:0] m_c [16];

  always @(posedge clock) begin : model
    logic hit;
    logic wrap;
    logic [15:0] nb;
    int g;
    if (RST) begin
      m_state <= 0;
      m_div   <= 0;
      m_col   <= 0;
      m_per   <= 8;
      m_lfsr  <= 8'hA5;
      m_score <= 8'd0;
      m_crash <= 1'b0;
      for (int c = 0; c < 16; c++) m_c[c] <= 16'h0;
    end else begin
      m_lfsr <= {m_lfsr[6:0],
                 m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      hit  = (m_state == 1) && m_c[15][bus.bird_index];
      wrap = (m_state == 1) && bus.run && (m_div == m_per - 1);
      if (m_state == 0 && bus.run) m_state <= 1;
      if (hit) begin
        m_state <= 2;
        m_crash <= 1'b1;
      end
      if (m_state == 1 && bus.run) begin
        m_div <= wrap ? 0 : m_div + 1;
`ifdef PIPE_SPEEDUP_EN
        if (wrap) m_per <= (8 - int'(m_score) / 8 < 2) ? 2
                         : 8 - int'(m_score) / 8;
`endif
      end
      if (wrap && !hit) begin
        nb = 16'h0;
        if (m_col == 0) begin
          g = int'(m_lfsr[3:0]);
          if (g > 12) g = g - 4;
          for (int r = 0; r < 16; r++) nb[r] = (r < g) || (r > g + 3);
        end
        m_c[0] <= nb;
        for (int c = 1; c < 16; c++) m_c[c] <= m_c[c-1];
        if (m_c[15] != 16'h0 && m_score != 8'hFF) m_score <= m_score + 8'd1;
        m_col <= (m_col == 5) ? 0 : m_col + 1;
      end
    end
  end

  function automatic logic [15:0] col_of(input frame_t f, input int c);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = f[r][c];
    return v;
  endfunction

  function automatic frame_t model_frame();
    frame_t f;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) f[r][c] = m_c[c][r];
    return f;
  endfunction

  function automatic logic [3:0] safe_row();
    for (int r = 0; r < 16; r++)
      if (!m_c[15][r]) return 4'(r);
    return 4'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (auto_bird) bus.bird_index = safe_row();
  endtask

  task automatic wait_steps(input int n, output bit ok);
    int seen;
    int guard;
    seen = 0;
    guard = 0;
    while (seen < n && guard < n * 64 + 64) begin
      tick();
      guard++;
      if (bus.step_pulse) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.run = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    int sp;
    auto_bird = 0;
    bus.bird_index = 4'd0;
    do_reset();
    sp = 0;
    repeat (20) begin
      tick();
      if (bus.step_pulse) sp++;
    end
    vec++;
    if (bus.light !== '0) begin
      miss++; $display("FAIL reset_light: got %h want 0", bus.light);
    end
    vec++;
    if (bus.score !== 8'd0) begin
      miss++; $display("FAIL reset_score: got %0d want 0", bus.score);
    end
    vec++;
    if (bus.crash !== 1'b0) begin
      miss++; $display("FAIL reset_crash: got %b want 0", bus.crash);
    end
    vec++;
    if (sp !== 0) begin
      miss++; $display("FAIL idle_pulses: got %0d want 0", sp);
    end
  endtask

  task automatic test_spawn_scroll();
    bit ok;
    int t0;
    int t1;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    t0 = cyc;
    wait_steps(1, ok);
    t1 = cyc;
    vec++;
    if (!ok || (t1 - t0) != 9) begin
      miss++; $display("FAIL first_step: got %0d cycles want 9", t1 - t0);
    end
    vec++;
    if (col_of(bus.light, 0) !== 16'hC3FF) begin
      miss++;
      $display("FAIL spawn_col0: got %h want c3ff", col_of(bus.light, 0));
    end
    vec++;
    if (bus.light !== model_frame()) begin
      miss++;
      $display("FAIL spawn_frame: got %h want %h", bus.light, model_frame());
    end
    wait_steps(1, ok);
    vec++;
    if (!ok || (cyc - t1) != 8) begin
      miss++; $display("FAIL step_period: got %0d want 8", cyc - t1);
    end
    wait_steps(5, ok);
    vec++;
    if (!ok || col_of(bus.light, 6) !== 16'hC3FF ||
        col_of(bus.light, 3) !== 16'h0 ||
        col_of(bus.light, 0) === 16'h0) begin
      miss++;
      $display("FAIL spacing: got col6 %h col3 %h col0 %h want c3ff 0 nonzero",
               col_of(bus.light, 6), col_of(bus.light, 3),
               col_of(bus.light, 0));
    end
    wait_steps(9, ok);
    vec++;
    if (!ok || col_of(bus.light, 15) !== 16'hC3FF) begin
      miss++;
      $display("FAIL scroll_col15: got %h want c3ff", col_of(bus.light, 15));
    end
    vec++;
    if (bus.light !== model_frame() || bus.score !== 8'd0) begin
      miss++;
      $display("FAIL step16_frame: got %h score %0d want %h score 0",
               bus.light, bus.score, model_frame());
    end
  endtask

  task automatic test_score();
    bit ok;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    wait_steps(17, ok);
    vec++;
    if (!ok || bus.score !== 8'd1) begin
      miss++; $display("FAIL score_pass1: got %0d want 1", bus.score);
    end
    wait_steps(5, ok);
    vec++;
    if (!ok || bus.score !== 8'd1) begin
      miss++; $display("FAIL score_hold: got %0d want 1", bus.score);
    end
    wait_steps(1, ok);
    vec++;
    if (!ok || bus.score !== 8'd2) begin
      miss++; $display("FAIL score_pass2: got %0d want 2", bus.score);
    end
    wait_steps(1548, ok);
    vec++;
    if (!ok || bus.score !== 8'd255 || bus.crash !== 1'b0) begin
      miss++;
      $display("FAIL score_sat: got %0d crash %b want 255 crash 0",
               bus.score, bus.crash);
    end
    vec++;
    if (bus.light !== model_frame() || m_score !== 8'd255) begin
      miss++;
      $display("FAIL score_frame: got %h want %h", bus.light, model_frame());
    end
  endtask

  task automatic test_collision();
    bit ok;
    int sp;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    wait_steps(16, ok);
    vec++;
    if (!ok || bus.crash !== 1'b0) begin
      miss++; $display("FAIL precrash: got %b want 0", bus.crash);
    end
    auto_bird = 0;
    bus.bird_index = 4'd0;
    tick();
    vec++;
    if (bus.crash !== 1'b1) begin
      miss++; $display("FAIL crash_edge: got %b want 1", bus.crash);
    end
    sp = 0;
    bus.run = 1'b0;
    repeat (5) begin
      tick();
      if (bus.step_pulse) sp++;
    end
    bus.run = 1'b1;
    repeat (20) begin
      tick();
      if (bus.step_pulse) sp++;
    end
    vec++;
    if (sp !== 0 || bus.score !== 8'd0 || bus.crash !== 1'b1 ||
        col_of(bus.light, 15) !== 16'hC3FF) begin
      miss++;
      $display("FAIL crash_hold: got pulses %0d score %0d crash %b col15 %h want 0 0 1 c3ff",
               sp, bus.score, bus.crash, col_of(bus.light, 15));
    end
    vec++;
    if (bus.light !== model_frame()) begin
      miss++;
      $display("FAIL crash_frame: got %h want %h", bus.light, model_frame());
    end
    do_reset();
    vec++;
    if (bus.light !== '0 || bus.crash !== 1'b0 || bus.score !== 8'd0) begin
      miss++;
      $display("FAIL crash_rst: got %h crash %b score %0d want 0 0 0",
               bus.light, bus.crash, bus.score);
    end
  endtask

  task automatic test_pause();
    bit ok;
    int t2;
    int sp;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    wait_steps(2, ok);
    t2 = cyc;
    repeat (3) tick();
    bus.run = 1'b0;
    sp = 0;
    repeat (30) begin
      tick();
      if (bus.step_pulse) sp++;
    end
    vec++;
    if (!ok || sp !== 0 || col_of(bus.light, 1) !== 16'hC3FF ||
        bus.light !== model_frame()) begin
      miss++;
      $display("FAIL pause_hold: got pulses %0d col1 %h want 0 c3ff",
               sp, col_of(bus.light, 1));
    end
    bus.run = 1'b1;
    wait_steps(1, ok);
    vec++;
    if (!ok || (cyc - t2) != 38 || col_of(bus.light, 2) !== 16'hC3FF) begin
      miss++;
      $display("FAIL pause_resume: got %0d cycles col2 %h want 38 c3ff",
               cyc - t2, col_of(bus.light, 2));
    end
  endtask

  task automatic test_step_collision();
    bit ok;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    wait_steps(16, ok);
    repeat (7) tick();
    vec++;
    if (!ok || bus.crash !== 1'b0 || bus.step_pulse !== 1'b0) begin
      miss++;
      $display("FAIL presync: got crash %b pulse %b want 0 0",
               bus.crash, bus.step_pulse);
    end
    auto_bird = 0;
    bus.bird_index = 4'd0;
    tick();
    vec++;
    if (bus.step_pulse !== 1'b0 || bus.crash !== 1'b1) begin
      miss++;
      $display("FAIL sync_crash: got pulse %b crash %b want 0 1",
               bus.step_pulse, bus.crash);
    end
    vec++;
    if (col_of(bus.light, 15) !== 16'hC3FF || bus.score !== 8'd0 ||
        bus.light !== model_frame()) begin
      miss++;
      $display("FAIL sync_noshift: got col15 %h score %0d want c3ff 0",
               col_of(bus.light, 15), bus.score);
    end
  endtask

`ifdef PIPE_SPEEDUP_EN
  task automatic test_speedup();
    bit ok;
    int g;
    int ta;
    do_reset();
    bus.run = 1'b1;
    auto_bird = 1;
    g = 0;
    while (bus.score < 8'd16 && g < 400) begin
      wait_steps(1, ok);
      g++;
    end
    wait_steps(1, ok);
    ta = cyc;
    wait_steps(1, ok);
    vec++;
    if (!ok || (cyc - ta) != 6) begin
      miss++; $display("FAIL speed16: got %0d want 6", cyc - ta);
    end
    g = 0;
    while (bus.score < 8'd64 && g < 600) begin
      wait_steps(1, ok);
      g++;
    end
    wait_steps(1, ok);
    ta = cyc;
    wait_steps(1, ok);
    vec++;
    if (!ok || (cyc - ta) != 2 || bus.score !== 8'd64) begin
      miss++;
      $display("FAIL speed64: got %0d score %0d want 2 64", cyc - ta, bus.score);
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    bus.run = 1'b0;
    bus.bird_index = 4'd0;
    test_reset();
    test_spawn_scroll();
    test_score();
    test_collision();
    test_pause();
    test_step_collision();
`ifdef PIPE_SPEEDUP_EN
    test_speedup();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Upstream producer of the 16x16 green pipe frame consumed by the LED display stage.
- Bird sits at column bit 15 and moves only vertically; `bird_index` comes from the bird-physics stage.
- Generates one-column pipes, each with a random gap:
  - new pipes enter at bit 0;
  - every scroll step shifts them one bit toward bit 15;
  - they exit past bit 15.
- Also detects collision with the bird and counts passed pipes (score).

Parameters:
- STEP_CYCLES, 8: clock cycles per scroll step (>=2).
- SPACING, 6: scroll steps between pipe spawns (>=2).
- GAP, 4: gap height in rows (2..8).

Ports:
- clock  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- run  in  1  level; 1 = play, 0 = pause.
- bird_index  in  4  bird row 0..15.
- light  out  16x16  pipe frame; light[row][col], registered.
- step_pulse  out  1  one-cycle high on each scroll step.
- crash  out  1  high once a collision has occurred; sticky until RST.
- score  out  8  pipes passed; saturates at 255.

Behaviour:
- Reset (RST=1 at a clock edge) forces, on that edge:
  - light=0, crash=0, score=0, step_pulse=0;
  - state=IDLE, div_cnt=0, col_cnt=0, lfsr=8'hA5.
- RST mid-game has the same effect.
- States:
  - IDLE -> RUN when run=1.
  - RUN -> CRASH on collision.
  - CRASH is terminal until RST.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock in every state except during reset.
  - Never all-zero.
- Divider:
  - In RUN with run=1, div_cnt increments each clock.
  - When div_cnt==STEP_CYCLES-1, div_cnt wraps to 0 and a step occurs that cycle.
  - run=0 in RUN freezes div_cnt, col_cnt and light (pause); the state stays RUN.
- Step (registered, takes effect on the step edge):
  - For every row r: light[r] <= {light[r][14:0], nb[r]}.
  - step_pulse is high for the following cycle.
- Spawn:
  - When col_cnt==0 at a step:
    - gt=lfsr[3:0];
    - if gt>16-GAP then gt=gt-GAP;
    - nb[r]=1 for rows outside [gt, gt+GAP-1], else 0.
  - Otherwise nb=0.
  - col_cnt increments per step and wraps at SPACING-1.
  - The first step after reset therefore spawns a pipe.
- Score:
  - At a step, if any light[r][15] was 1 before the shift, score increments (saturating).
  - Score is never incremented in the cycle a crash is detected.
- Collision:
  - In RUN, evaluated every clock (including while paused) on the registered frame: light[bird_index][15]==1.
  - When true, next state is CRASH and crash=1 on the next edge.
  - If a step coincides with detection, the step is suppressed: no shift, no score, no step_pulse.
- CRASH:
  - light, score and crash are held.
  - run is ignored.
- Width rule: score is 8-bit unsigned and saturates; it does not wrap.

Optional Feature:
- Macro: PIPE_SPEEDUP_EN.
- Defined:
  - The step period is STEP_CYCLES minus floor(score/8).
  - The period is floored at 2 cycles.
  - The new period applies from the next divider wrap.
- Undefined: the period is fixed at STEP_CYCLES.

Decomposition:
- Package flappy_pkg:
  - ROWS=16, COLS=16;
  - typedef frame_t (logic [15:0][15:0]);
  - enum game_state_t {IDLE, RUN, CRASH};
  - LFSR_SEED=8'hA5.
- One sub-module, pipe_lfsr:
  - 8-bit LFSR with a synchronous reset to the seed;
  - outputs the current value.

Test Plan:
- Reset/idle: RST=1 for 2 cycles, then run=0 for 20 cycles -> light=0, score=0, crash=0, no step_pulse.
- Spawn and scroll:
  - Stimulus: STEP_CYCLES=8, run=1, bird_index parked in the gap.
  - Step timing: step_pulse every 8 cycles.
  - First column: after step 1, bit 0 holds a pipe whose 4 zero rows start at the gap top derived from the LFSR state at the spawn edge.
  - Scrolling: the same pattern reaches bit 15 after 16 steps.
  - Spacing: the next pipe appears 6 steps later.
- Score:
  - Stimulus: bird kept in every gap via a model-driven bird_index.
  - Response: score increments on the step where each pipe leaves bit 15.
  - Saturation: forcing 260 passes ends at score=255.
- Collision:
  - Stimulus: bird_index=0 while the pipe at bit 15 has row 0 set.
  - Response: crash=1 on the next edge; light and score are frozen; run toggling has no effect; RST clears everything.
- Pause/simultaneity:
  - run=0 for 30 cycles mid-step -> div_cnt and light unchanged, and the step resumes at the correct count.
  - Collision on a step cycle -> no shift, no step_pulse.
- PIPE_SPEEDUP_EN: score=16 -> step period measured as 6 cycles; score=64 -> period 2.
